// File: rtl/spmv_pkg.sv
// Shared SpMV definitions: sequencer state encoding, default sizes and the
// 4-bit debug state width also used by the M10K reader FSMs.
package spmv_pkg;

  localparam int DEF_NUM_BANKS = 2;
  localparam int DEF_CNT_W     = 8;
  localparam int STATE_W       = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_REQ  = 4'd1,
    ST_LOAD_WAIT = 4'd2,
    ST_STREAM    = 4'd3,
    ST_RELEASE   = 4'd4,
    ST_DONE      = 4'd5
  } seq_state_e;

endpackage

// File: rtl/m10k_idx_streamer.sv
// STREAM-phase nonzero index generator: latches (and clamps) nnz on an accepted
// go, then walks 0..nnz-1 under a valid/ready handshake without ever wrapping.
module m10k_idx_streamer
  import spmv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_latch,
  input  logic [CNT_W:0]   i_nnz,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_nnz_zero,
  output logic             o_xfer_last
);

  localparam logic [CNT_W:0]   NNZ_MAX = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]   ONE_N   = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W:0] nnz_q;
  logic [CNT_W:0] last_idx;
  logic           xfer;

  assign last_idx    = nnz_q - ONE_N;
  assign xfer        = o_valid & i_ready;
  assign o_last      = o_valid & ({1'b0, o_count} == last_idx);
  assign o_xfer_last = xfer & o_last;
  assign o_nnz_zero  = (nnz_q == '0);

  // The final transfer always arrives together with i_clear, so the index
  // stops at nnz-1 even for nnz = 2^CNT_W.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      nnz_q   <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_latch) begin
        nnz_q <= (i_nnz > NNZ_MAX) ? NNZ_MAX : i_nnz;
      end
      if (i_clear) begin
        o_valid <= 1'b0;
        o_count <= '0;
      end else if (i_start) begin
        o_valid <= 1'b1;
        o_count <= '0;
      end else if (xfer) begin
        o_count <= o_count + ONE_C;
      end
    end
  end

endmodule

// File: rtl/m10k_load_sequencer.sv
// Sequences the per-bank M10K readers, streams nonzero indices, then resets the readers.
// Optional LOAD_SEQ_TIMEOUT_EN adds a per-bank load watchdog driving the sticky o_error.
module m10k_load_sequencer
  import spmv_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIMEOUT   = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_go,
  input  logic                 i_abort,
  input  logic [CNT_W:0]       i_nnz,
  input  logic [NUM_BANKS-1:0] i_bank_done,
  input  logic                 i_ready,
  output logic [NUM_BANKS-1:0] o_read_start,
  output logic [NUM_BANKS-1:0] o_read_reset,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_valid,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [STATE_W-1:0]   o_state
);

  localparam int              BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  if (NUM_BANKS < 1 || NUM_BANKS > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("m10k_load_sequencer: NUM_BANKS must be 1..8 and TIMEOUT at least 1");
  end

  seq_state_e        state;
  logic [BANK_W-1:0] bank;
  logic [BANK_W-1:0] bank_nxt;
  logic              bank_done;
  logic              last_bank;
  logic              go_accept;
  logic              stream_start;
  logic              stream_clear;
  logic              nnz_zero;
  logic              xfer_last;
  logic              timeout_hit;

  assign bank_nxt  = bank + BANK_W'(1);
  assign bank_done = i_bank_done[bank];
  assign last_bank = (bank == LAST_BANK);
  assign go_accept = (state == ST_IDLE) & i_go;

  // Streamer control mirrors the FSM transitions so o_valid is registered
  // together with the state change into STREAM or out of it.
  assign stream_start = (state == ST_LOAD_WAIT) & bank_done & last_bank &
                        ~i_abort & ~nnz_zero;
  assign stream_clear = ((state == ST_STREAM) & (i_abort | xfer_last)) |
                        (state == ST_RELEASE);

  m10k_idx_streamer #(
    .CNT_W (CNT_W)
  ) u_streamer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_latch     (go_accept),
    .i_nnz       (i_nnz),
    .i_start     (stream_start),
    .i_clear     (stream_clear),
    .i_ready     (i_ready),
    .o_count     (o_count),
    .o_valid     (o_valid),
    .o_last      (o_last),
    .o_nnz_zero  (nnz_zero),
    .o_xfer_last (xfer_last)
  );

`ifdef LOAD_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            error_q;

  assign timeout_hit = (state == ST_LOAD_WAIT) & ~bank_done &
                       (wd_cnt == WD_W'(TIMEOUT - 1));
  assign o_error     = error_q;

  // LOAD_REQ always precedes LOAD_WAIT, so clearing there restarts the count per bank.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == ST_LOAD_REQ) begin
        wd_cnt <= '0;
      end else if ((state == ST_LOAD_WAIT) && !bank_done) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (go_accept) begin
        error_q <= 1'b0;
      end else if (timeout_hit && !i_abort) begin
        error_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_error     = 1'b0;
`endif

  // Pulse outputs default low and are raised only on the transition into the
  // state that owns them, keeping start and reset pulses mutually exclusive.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      bank         <= '0;
      o_read_start <= '0;
      o_read_reset <= '0;
      o_done       <= 1'b0;
    end else begin
      o_read_start <= '0;
      o_read_reset <= '0;
      o_done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_go) begin
            bank         <= '0;
            o_read_start <= NUM_BANKS'(1);
            state        <= ST_LOAD_REQ;
          end
        end
        ST_LOAD_REQ: begin
          if (i_abort) begin
            o_read_reset <= '1;
            state        <= ST_RELEASE;
          end else begin
            state <= ST_LOAD_WAIT;
          end
        end
        ST_LOAD_WAIT: begin
          if (i_abort || timeout_hit) begin
            o_read_reset <= '1;
            state        <= ST_RELEASE;
          end else if (bank_done) begin
            if (!last_bank) begin
              bank         <= bank_nxt;
              o_read_start <= NUM_BANKS'(1) << bank_nxt;
              state        <= ST_LOAD_REQ;
            end else if (nnz_zero) begin
              o_read_reset <= '1;
              state        <= ST_RELEASE;
            end else begin
              state <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (i_abort || xfer_last) begin
            o_read_reset <= '1;
            state        <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          o_done <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

endmodule

// File: doc/m10k_load_sequencer.md
Name: m10k_load_sequencer

Overview:
Controller that sequences the per-bank M10K reader FSMs (row_ptr + col_idx loaders) for the SpMV engine. On a go pulse it starts each bank's reader in turn, waits for its done, then sweeps the shared nonzero index count 0..nnz-1 to the datapath with a valid/ready handshake. It finally pulses read_reset to all banks so they return to idle with cleared buffers. Sits between the top-level SpMV control and the NUM_BANKS reader instances.

Parameters:
NUM_BANKS, 2, number of reader instances sequenced (1..8)
CNT_W, 8, width of the nonzero index driven to the readers' i_count
TIMEOUT, 64, watchdog limit in cycles per bank load (used only with the optional feature)

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous, active-high reset
i_go  input  1  start pulse; sampled only in IDLE
i_abort  input  1  abandon the current operation; go to RELEASE
i_nnz  input  CNT_W+1  nonzero count (0..2^CNT_W), latched on accepted go
i_bank_done  input  NUM_BANKS  per-bank reader done level
i_ready  input  1  datapath accepts the current index
o_read_start  output  NUM_BANKS  one-hot, 1-cycle start pulse to a bank reader
o_read_reset  output  NUM_BANKS  1-cycle reset pulse to all bank readers
o_count  output  CNT_W  current nonzero index
o_valid  output  1  o_count is valid
o_last  output  1  o_count == nnz-1, qualified by o_valid
o_busy  output  1  state != IDLE
o_done  output  1  1-cycle completion pulse
o_error  output  1  sticky watchdog error (tied 0 without the optional feature)
o_state  output  4  current state, for debug

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; bank index 0; latched nnz 0.
- States: IDLE=0, LOAD_REQ=1, LOAD_WAIT=2, STREAM=3, RELEASE=4, DONE=5. Unused encodings go to IDLE.
- IDLE: on i_go, latch nnz (values >2^CNT_W clamp to 2^CNT_W), set bank=0, go to LOAD_REQ. In every other state i_go is ignored.
- LOAD_REQ: o_read_start[bank]=1 for exactly this cycle, then go to LOAD_WAIT.
- LOAD_WAIT: wait for i_bank_done[bank].
  - When it rises and bank<NUM_BANKS-1: bank++, go to LOAD_REQ.
  - When it rises on the last bank: go to STREAM if nnz>0, else RELEASE.
  - Done is level-sensitive. A done already high on entry is accepted in the first LOAD_WAIT cycle.
- STREAM: o_valid=1, o_count=idx (starts 0).
  - idx advances only on i_valid&i_ready (i.e. o_valid&i_ready).
  - o_count is held stable while i_ready=0.
  - o_last=1 when idx==nnz-1. A transfer with o_last set goes to RELEASE.
  - nnz=2^CNT_W: idx reaches 2^CNT_W-1 and never wraps.
- RELEASE: o_read_reset = all ones for exactly one cycle. Clear o_valid and idx. Go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. A new go is accepted in the following IDLE cycle, so minimum go-to-go spacing is the full sequence.
- Load latency per bank: 1 cycle (LOAD_REQ) plus the reader latency. The first o_valid appears the cycle after the last bank's done is seen.
- i_abort in LOAD_REQ, LOAD_WAIT or STREAM: go to RELEASE next cycle with no further start pulses and o_valid dropped.
  - If i_abort arrives with a final-index transfer in the same cycle, the transfer completes; both paths lead to RELEASE.
  - i_abort in IDLE, RELEASE or DONE: ignored.
- o_read_start and o_read_reset are never asserted in the same cycle. At most one start bit is set at a time.

Optional Feature:
LOAD_SEQ_TIMEOUT_EN:
- Defined: a watchdog counts cycles in LOAD_WAIT and clears on entry to that state.
  - At TIMEOUT cycles without done: set o_error (sticky until i_rst or the next accepted i_go) and go to RELEASE.
  - o_done still pulses in DONE.
- Undefined: no counter is built, o_error is tied 0, and LOAD_WAIT waits indefinitely.

Decomposition:
- Shared package spmv_pkg holds:
  - the state encoding constants;
  - CNT_W / NUM_BANKS defaults;
  - the 4-bit o_state debug width, common with the reader FSMs.
- One natural sub-module, m10k_idx_streamer: the STREAM-phase index counter with valid/ready/last and the clamp logic. The parent FSM keeps bank sequencing and the reset pulse.

Test Plan:
- NUM_BANKS=2, nnz=5, readers respond done 6 cycles after start, i_ready=1 -> start[0] pulse, then start[1] pulse after done[0]; o_count 0,1,2,3,4 on consecutive cycles; o_last with count=4; read_reset=2'b11 one cycle; o_done one cycle later.
- nnz=4, i_ready toggles 1,0,0,1,1,0,1 -> o_count holds while ready=0; exactly 4 transfers; o_last on the index-3 transfer only.
- nnz=0 -> both banks loaded; o_valid never asserted; RELEASE immediately after done[1]; o_done pulses.
- nnz=256, CNT_W=8, ready=1 -> 256 transfers; last o_count=8'hFF with o_last; no wrap to 0.
- i_abort asserted in STREAM at count=2 -> o_valid low next cycle, read_reset pulse, o_done pulse; a go during DONE is ignored.
- With LOAD_SEQ_TIMEOUT_EN, TIMEOUT=64, done[1] never rises -> after 64 LOAD_WAIT cycles o_error=1, reset pulse, o_done pulse; the next accepted go clears o_error. i_rst mid-STREAM -> all outputs 0 immediately.
